// File: rtl/tdm_demux_rx_if.sv
// Bundles the serial slot stream and the parallel frame outputs of tdm_demux_rx.
// The master drives the slot stream; the slave is the receiver.
`default_nettype none

interface tdm_demux_rx_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                      in_valid;
  logic [WIDTH-1:0]          in_data;
  logic                      in_sof;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic                      out_valid;
  logic                      frame_err;
  logic                      locked;

  modport master (
    output in_valid, in_data, in_sof,
    input  out_data, out_valid, frame_err, locked
  );

  modport slave (
    input  in_valid, in_data, in_sof,
    output out_data, out_valid, frame_err, locked
  );
endinterface

`default_nettype wire

// File: rtl/tdm_demux_rx.sv
// TDM demultiplexing receiver: collects one word per slot after a start-of-frame
// marker and publishes the whole frame at once with a one-cycle strobe.
`default_nettype none

module tdm_demux_rx #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux_rx_if.slave bus
);
  localparam int SW = $clog2(CHANNELS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  localparam logic [0:0] S_HUNT    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic                      out_valid_q;
  logic                      frame_err_q;

  logic          store;
  logic          publish;
  logic          err;
  logic [SW-1:0] wr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (bus.in_valid) begin
      case (state_q)
        S_HUNT: begin
          if (bus.in_sof) begin
            state_d = S_COLLECT;
            slot_d  = SLOT_ONE;
          end
        end
        S_COLLECT: begin
          if (bus.in_sof) begin
            slot_d = SLOT_ONE;
          end else if (slot_q == '0) begin
            state_d = S_HUNT;
            slot_d  = '0;
          end else if (slot_q == LAST_SLOT) begin
            slot_d = '0;
          end else begin
            slot_d = slot_q + SLOT_ONE;
          end
        end
        default: begin
          state_d = S_HUNT;
          slot_d  = '0;
        end
      endcase
    end
  end

  // A marker always restarts the frame at slot 0, whether aligned or not.
  always_comb begin
    store   = 1'b0;
    publish = 1'b0;
    err     = 1'b0;
    wr_idx  = bus.in_sof ? '0 : slot_q;
    if (bus.in_valid) begin
      case (state_q)
        S_HUNT: begin
          store = bus.in_sof;
        end
        S_COLLECT: begin
          if (bus.in_sof) begin
            store = 1'b1;
            err   = (slot_q != '0);
          end else if (slot_q == '0) begin
            err = 1'b1;
          end else begin
            store   = 1'b1;
            publish = (slot_q == LAST_SLOT);
          end
        end
        default: begin
          store = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out_data_d = shadow_q;
    out_data_d[(CHANNELS-1)*WIDTH +: WIDTH] = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      out_valid_q <= publish;
      frame_err_q <= err;
      if (store) begin
        shadow_q[int'(wr_idx)*WIDTH +: WIDTH] <= bus.in_data;
      end
      if (publish) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.locked    = (state_q == S_COLLECT);
endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_rx.sv
// Bench for tdm_demux_rx: directed scenarios plus random traffic, compared every
// cycle against a queue-based frame model.
`default_nettype none

module tb_tdm_demux_rx;
  localparam int CH = 4;
  localparam int W  = 8;

  logic clk;
  logic rst_n;

  tdm_demux_rx_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  tdm_demux_rx #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: the partial frame is just the list of words seen so far.
  bit            m_locked;
  logic [W-1:0]  m_q[$];
  logic [CH*W-1:0] m_out;
  bit            m_valid;
  bit            m_err;
  int            pulse_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_q.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1'b1;
          m_q.delete();
          m_q.push_back(d);
        end
      end else if (s) begin
        if (m_q.size() != 0) m_err = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == CH) begin
          for (int k = 0; k < CH; k++) m_out[k*W +: W] = m_q[k];
          m_valid = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("frame_err", 64'(bus.frame_err), 64'(m_err));
    check("locked",    64'(bus.locked),    64'(m_locked));
    check("out_data",  64'(bus.out_data),  64'(m_out));
    if (bus.out_valid) pulse_cnt++;
  endtask

  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [W-1:0] base);
    for (int k = 0; k < CH; k++) step(1'b1, k == 0, base + W'(k));
  endtask

  int ts;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pulse_cnt = 0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    rst_n = 1'b0;
    model_reset();

    // Held reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_sof   = 1'($urandom);
      bus.in_data  = W'($urandom);
      @(posedge clk);
      #1;
      compare_all();
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal back-to-back frames
    pulse_cnt = 0;
    step(1'b1, 1'b1, 8'hA0);
    step(1'b1, 1'b0, 8'hA1);
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);
    check("nominal_A", 64'(bus.out_data), 64'h00000000A3A2A1A0);
    step(1'b1, 1'b1, 8'hB0);
    step(1'b1, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 8'hB2);
    step(1'b1, 1'b0, 8'hB3);
    check("nominal_B", 64'(bus.out_data), 64'h00000000B3B2B1B0);
    check("nominal_pulses", 64'(pulse_cnt), 64'd2);

    // Stall between slots 1 and 2
    step(1'b1, 1'b1, 8'hA0);
    step(1'b1, 1'b0, 8'hA1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, W'($urandom));
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);
    check("stall_frame", 64'(bus.out_data), 64'h00000000A3A2A1A0);

    // Drop marker -> unlock, then hunt
    step(1'b1, 1'b0, 8'h77);
    check("drop_sof_locked", 64'(bus.locked), 64'd0);
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    send_frame(8'h40);
    check("hunt_frame", 64'(bus.out_data), 64'h0000000043424140);

    // Misaligned marker
    step(1'b1, 1'b1, 8'h50);
    step(1'b1, 1'b0, 8'h51);
    step(1'b1, 1'b1, 8'h60);
    check("misalign_err", 64'(bus.frame_err), 64'd1);
    check("misalign_keep", 64'(bus.out_data), 64'h0000000043424140);
    step(1'b1, 1'b0, 8'h61);
    step(1'b1, 1'b0, 8'h62);
    step(1'b1, 1'b0, 8'h63);
    check("misalign_recover", 64'(bus.out_data), 64'h0000000063626160);

    // Asynchronous reset mid-frame, between edges
    step(1'b1, 1'b1, 8'h70);
    step(1'b1, 1'b0, 8'h71);
    step(1'b1, 1'b0, 8'h72);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h73);
    send_frame(8'h90);
    check("post_reset_frame", 64'(bus.out_data), 64'h0000000093929190);

    // Random traffic, mostly aligned markers with occasional corruption
    ts = 0;
    for (int i = 0; i < 800; i++) begin
      logic v, s;
      v = ($urandom_range(3) != 0);
      if (ts == 0) s = ($urandom_range(7) != 0);
      else         s = ($urandom_range(11) == 0);
      step(v, s, W'($urandom));
      if (v) ts = s ? 1 : (ts + 1) % CH;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
